uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, registered tx output.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by parity_odd) for 8E1/8O1 frames.
module uart_tx #(
   parameter int clk_freq   = 12000000,
   parameter int baud       = 115200,
   parameter bit parity_odd = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       start,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   // BIT_TICKS below 2 is not supported.
   localparam int BIT_TICKS = clk_freq / baud;
   localparam int CNT_W     = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_TICKS - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`else
   localparam bit unused_parity_odd = parity_odd;
`endif

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [7:0]       r_data;
   logic             r_tx;
   logic             r_busy;
   logic             r_done;

   logic             w_tick;
   logic [2:0]       w_bit_nxt;

   assign w_tick    = (r_cnt == CNT_MAX);
   assign w_bit_nxt = r_bit + 3'd1;

`ifdef UART_TX_PARITY_EN
   logic w_parity;
   assign w_parity = (^r_data) ^ parity_odd;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_data  <= 8'h00;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_START;
                  r_data  <= data;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_bit   <= '0;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_state <= ST_DATA;
                  r_tx    <= r_data[0];
                  r_bit   <= '0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_cnt <= '0;
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= ST_PARITY;
                     r_tx    <= w_parity;
`else
                     r_state <= ST_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit <= w_bit_nxt;
                     r_tx  <= r_data[w_bit_nxt];
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
`endif
            ST_STOP: begin
               if (w_tick) begin
                  r_done <= 1'b1;
                  r_cnt  <= '0;
                  r_bit  <= '0;
                  // A request at frame end starts the next frame with no idle gap.
                  if (start) begin
                     r_state <= ST_START;
                     r_data  <= data;
                     r_tx    <= 1'b0;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_tx    <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_bit   <= '0;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule
